hazard_stall_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32I core. It is the stall/flush side of the bypass network: it handles every hazard that forwarding cannot resolve.
- Load-use hazards: inserts a bubble.
- Taken branches/jumps: flushes IF/ID and ID/EX.
- Data-memory wait states: freezes the pipeline, with a timeout watchdog.
Sits beside the forwarding logic in ID/EX; drives the pipeline-register write enables and the PC write enable.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_wait_timer.sv | 66 ++++++
 rtl/hazard_stall_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The optional performance counters are enabled with HAZARD_PERF_CNT_EN.
package hazard_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_TIMEOUT  = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int MEM_TIMEOUT_DEF = 16;

    // Counter must hold the value MEM_TIMEOUT itself.
    function automatic int wait_cnt_w(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    localparam int WAIT_CNT_W = wait_cnt_w(MEM_TIMEOUT_DEF);

endpackage

// File: rtl/hazard_wait_timer.sv
// Data-memory wait FSM (RUN / MEM_WAIT / TIMEOUT) with its consecutive-wait
// watchdog counter. TIMEOUT is terminal until reset.
module hazard_wait_timer
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      freeze,
    input  logic      dmem_ready,
    output hz_state_t state,
    output logic      mem_timeout
);

    localparam int             CW      = wait_cnt_w(MEM_TIMEOUT);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MEM_TIMEOUT);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    hz_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HZ_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            HZ_RUN: begin
                if (freeze) begin
                    state_d = HZ_MEM_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            HZ_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = HZ_RUN;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_MAX) begin
                    state_d = HZ_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HZ_TIMEOUT: begin
                state_d = HZ_TIMEOUT;
            end
            default: begin
                state_d = HZ_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    assign state       = state_q;
    assign mem_timeout = (state_q == HZ_TIMEOUT);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage core: load-use bubble, branch flush,
// data-memory freeze with watchdog. Perf counters exist only with HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_uses_rs1,
    input  logic             ID_uses_rs2,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_MemRead,
    input  logic             EX_branch_taken,
    input  logic             EX_MEM_MemReq,
    input  logic             dmem_ready,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             MEM_WB_Bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    hz_state_t state;
    logic      timeout_st;
    logic      lu;
    logic      freeze;
    logic      frozen;

    assign lu = ID_EX_MemRead && (ID_EX_rd != REG_ZERO) &&
                ((ID_uses_rs1 && (ID_EX_rd == ID_rs1)) ||
                 (ID_uses_rs2 && (ID_EX_rd == ID_rs2)));

    assign freeze = EX_MEM_MemReq && !dmem_ready;

    // MEM_WAIT keeps the pipe frozen on dmem_ready alone; the request may drop.
    assign frozen = ((state == HZ_RUN) && freeze) ||
                    ((state == HZ_MEM_WAIT) && !dmem_ready);

    hazard_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .dmem_ready  (dmem_ready),
        .state       (state),
        .mem_timeout (timeout_st)
    );

    always_comb begin
        PC_Write      = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_Write   = 1'b1;
        EX_MEM_Write  = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Flush   = 1'b0;
        MEM_WB_Bubble = 1'b0;
        mem_timeout   = 1'b0;
        if (!rst) begin
            if (timeout_st) begin
                PC_Write      = 1'b0;
                IF_ID_Write   = 1'b0;
                ID_EX_Write   = 1'b0;
                EX_MEM_Write  = 1'b0;
                MEM_WB_Bubble = 1'b1;
                mem_timeout   = 1'b1;
            end else if (frozen) begin
                PC_Write      = 1'b0;
                IF_ID_Write   = 1'b0;
                ID_EX_Write   = 1'b0;
                EX_MEM_Write  = 1'b0;
                MEM_WB_Bubble = 1'b1;
            end else if (EX_branch_taken) begin
                // ID instruction is squashed, so a load-use match is irrelevant.
                IF_ID_Flush = 1'b1;
                ID_EX_Flush = 1'b1;
            end else if (lu) begin
                PC_Write    = 1'b0;
                IF_ID_Write = 1'b0;
                ID_EX_Flush = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic             stall_evt;
    logic             flush_evt;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    assign stall_evt = !timeout_st && (frozen || (!EX_branch_taken && lu));
    assign flush_evt = !timeout_st && !frozen && EX_branch_taken;

    always_comb begin
        stall_cycles_d = stall_cycles_q + CNT_W'(stall_evt);
        flush_count_d  = flush_count_q + CNT_W'(flush_evt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the stall/flush rules.
module tb_hazard_stall_ctrl;

    localparam int T     = 4;
    localparam int CNT_W = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {PC, IF_ID_W, ID_EX_W, EX_MEM_W, IF_ID_Fl, ID_EX_Fl, Bubble, timeout}
    localparam logic [7:0] C_NORM = 8'b1111_0000;
    localparam logic [7:0] C_FRZ  = 8'b0000_0010;
    localparam logic [7:0] C_TMO  = 8'b0000_0011;
    localparam logic [7:0] C_BR   = 8'b1111_1100;
    localparam logic [7:0] C_LU   = 8'b0011_0100;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, mr, br, req, rdy;
    } stim_t;

    typedef struct {
        int          id;
        logic [7:0]  ctrl;
        logic [31:0] sc, fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] ID_rs1 = '0, ID_rs2 = '0, ID_EX_rd = '0;
    logic ID_uses_rs1 = 0, ID_uses_rs2 = 0, ID_EX_MemRead = 0;
    logic EX_branch_taken = 0, EX_MEM_MemReq = 0, dmem_ready = 0;
    logic PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
    logic IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble, mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    hazard_stall_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .ID_EX_rd(ID_EX_rd), .ID_EX_MemRead(ID_EX_MemRead),
        .EX_branch_taken(EX_branch_taken), .EX_MEM_MemReq(EX_MEM_MemReq),
        .dmem_ready(dmem_ready),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
        .ID_EX_Write(ID_EX_Write), .EX_MEM_Write(EX_MEM_Write),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
        .MEM_WB_Bubble(MEM_WB_Bubble), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    exp_t sbq[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model state: length of current frozen run, dead flag, counters.
    int          wait_run = 0;
    bit          dead = 0;
    logic [31:0] m_sc = '0, m_fc = '0;
    int          ncyc = 0;

    // mode 0: normal cycle, 1: rst held whole cycle, 2: rst asserted mid-cycle
    task automatic cycle(input stim_t s, input int mode);
        exp_t e;
        bit   lu_m;
        @(posedge clk); #1;
        ID_rs1 = s.rs1; ID_rs2 = s.rs2; ID_EX_rd = s.rd;
        ID_uses_rs1 = s.u1; ID_uses_rs2 = s.u2; ID_EX_MemRead = s.mr;
        EX_branch_taken = s.br; EX_MEM_MemReq = s.req; dmem_ready = s.rdy;
        rst = (mode == 1);
        if (mode == 2) begin #2; rst = 1'b1; end
        e.id = ncyc++;
        if (rst) begin
            e.ctrl = C_NORM; e.sc = '0; e.fc = '0;
            wait_run = 0; dead = 0; m_sc = '0; m_fc = '0;
        end else begin
            e.sc = m_sc; e.fc = m_fc;
            lu_m = s.mr && (s.rd != 0) &&
                   ((s.u1 && s.rd == s.rs1) || (s.u2 && s.rd == s.rs2));
            if (dead) begin
                e.ctrl = C_TMO;
            end else if (!s.rdy && (s.req || wait_run > 0)) begin
                e.ctrl = C_FRZ;
                m_sc++;
                wait_run++;
                if (wait_run > T) dead = 1;
            end else begin
                wait_run = 0;
                if (s.br) begin
                    e.ctrl = C_BR; m_fc++;
                end else if (lu_m) begin
                    e.ctrl = C_LU; m_sc++;
                end else begin
                    e.ctrl = C_NORM;
                end
            end
        end
        if (!PERF) begin e.sc = '0; e.fc = '0; end
        sbq.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if ({PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, IF_ID_Flush,
                     ID_EX_Flush, MEM_WB_Bubble, mem_timeout} !== e.ctrl)
                    $display("FAIL ctrl cyc %0d: got %b want %b", e.id,
                             {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                              IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble, mem_timeout},
                             e.ctrl);
                else passes++;
                checks++;
                if (stall_cycles !== e.sc)
                    $display("FAIL stall_cycles cyc %0d: got %0d want %0d", e.id, stall_cycles, e.sc);
                else passes++;
                checks++;
                if (flush_count !== e.fc)
                    $display("FAIL flush_count cyc %0d: got %0d want %0d", e.id, flush_count, e.fc);
                else passes++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s, z;
        int    hold;
        z = '{default: '0};

        // Reset with a freeze request present: reset outputs must win.
        s = z; s.req = 1; s.rdy = 0;
        cycle(s, 1); cycle(z, 1);
        cycle(z, 0);

        // Load-use on rs1, then load gone.
        s = z; s.mr = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1;
        cycle(s, 0);
        cycle(z, 0);
        // rd = x0 never stalls.
        s = z; s.mr = 1; s.rd = 0; s.rs1 = 0; s.u1 = 1;
        cycle(s, 0);
        // Branch beats load-use.
        s = z; s.mr = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1; s.br = 1;
        cycle(s, 0);
        cycle(z, 0);

        // Three wait cycles then release.
        s = z; s.req = 1; s.rdy = 0;
        repeat (3) cycle(s, 0);
        s.rdy = 1; cycle(s, 0);
        cycle(z, 0);

        // Branch held in EX across a freeze is acted on at release.
        s = z; s.req = 1; s.rdy = 0; s.br = 1;
        repeat (2) cycle(s, 0);
        s.rdy = 1; cycle(s, 0);
        cycle(z, 0);

        // Watchdog: five frozen cycles, then sticky timeout.
        s = z; s.req = 1; s.rdy = 0;
        repeat (7) cycle(s, 0);
        s.rdy = 1; repeat (2) cycle(s, 0);
        cycle(z, 1);
        cycle(z, 0);

        // Asynchronous reset in the middle of a wait.
        s = z; s.req = 1; s.rdy = 0;
        repeat (2) cycle(s, 0);
        cycle(s, 2);
        cycle(z, 0);

        // Random traffic with occasional long memory stalls and resets.
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            s.rs1 = 5'($urandom_range(0, 3));
            s.rs2 = 5'($urandom_range(0, 3));
            s.rd  = 5'($urandom_range(0, 3));
            s.u1  = 1'($urandom_range(0, 1));
            s.u2  = 1'($urandom_range(0, 1));
            s.mr  = 1'($urandom_range(0, 1));
            s.br  = ($urandom_range(0, 5) == 0);
            s.req = ($urandom_range(0, 2) == 0);
            if (hold == 0 && $urandom_range(0, 9) == 0) hold = $urandom_range(1, 7);
            s.rdy = (hold > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (hold > 0) hold--;
            if ($urandom_range(0, 59) == 0)      cycle(s, 1);
            else if ($urandom_range(0, 79) == 0) cycle(s, 2);
            else                                  cycle(s, 0);
        end

        repeat (3) @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending want 0", sbq.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
